// File: rtl/wb_mst_arb_if.sv
// ============================================================================
// Module   : wb_mst_arb_if
// Purpose  : Bundles the per-master request/response lanes and the shared
//            slave-side bus of the wb_mst_arb round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_mst_arb_if #(
  parameter int MASTERS = 4,
  parameter int AW      = 32
);
  // Per-master request lanes, master m occupies slice [m*W +: W]
  logic [MASTERS-1:0]    mst_cyc_i;
  logic [MASTERS-1:0]    mst_stb_i;
  logic [MASTERS-1:0]    mst_we_i;
  logic [MASTERS*AW-1:0] mst_adr_i;
  logic [MASTERS*32-1:0] mst_dat_i;
  logic [MASTERS*4-1:0]  mst_sel_i;
  logic [MASTERS-1:0]    mst_ack_o;
  logic [MASTERS-1:0]    mst_err_o;
  logic [31:0]           mst_dat_o;
  // Shared bus towards the slave decoder
  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [AW-1:0]         adr_o;
  logic [31:0]           dat_o;
  logic [3:0]            sel_o;
  logic                  ack_i;
  logic [31:0]           dat_i;
  logic [MASTERS-1:0]    gnt_o;

  // slave: the arbiter itself; master: the surrounding masters and slave
  modport slave (
    input  mst_cyc_i, mst_stb_i, mst_we_i, mst_adr_i, mst_dat_i, mst_sel_i,
    input  ack_i, dat_i,
    output mst_ack_o, mst_err_o, mst_dat_o,
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, gnt_o
  );

  modport master (
    output mst_cyc_i, mst_stb_i, mst_we_i, mst_adr_i, mst_dat_i, mst_sel_i,
    output ack_i, dat_i,
    input  mst_ack_o, mst_err_o, mst_dat_o,
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, gnt_o
  );
endinterface

`default_nettype wire

// File: rtl/wb_mst_arb.sv
// ============================================================================
// Module   : wb_mst_arb
// Purpose  : N-master to 1-slave Wishbone arbiter, round-robin grant held for
//            a whole CYC burst. Optional ACK timeout: WB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mst_arb #(
  parameter int MASTERS = 4,
  parameter int AW      = 32,
  parameter int TIMEOUT = 64
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  wb_mst_arb_if.slave   bus
);

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      last_q, last_d;

  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      cand;

  logic               g_cyc, g_stb, g_we;
  logic [AW-1:0]      g_adr;
  logic [DW-1:0]      g_dat;
  logic [SW-1:0]      g_sel;
  logic [IW-1:0]      g_idx;

  logic               busy;
  logic               stb_int;
  logic               to_fire;

  assign busy = (state_q == BUSY) && !rst_i;

  // Scan from farthest to nearest so the first requester after last_q wins
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = MASTERS; off >= 1; off--) begin
      cand = IW'((int'(last_q) + off) % MASTERS);
      if (bus.mst_cyc_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Granted-master mux, driven from the registered one-hot grant
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_idx = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (gnt_q[m]) begin
        g_cyc = bus.mst_cyc_i[m];
        g_stb = bus.mst_stb_i[m];
        g_we  = bus.mst_we_i[m];
        g_adr = bus.mst_adr_i[m*AW +: AW];
        g_dat = bus.mst_dat_i[m*DW +: DW];
        g_sel = bus.mst_sel_i[m*SW +: SW];
        g_idx = IW'(m);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          gnt_d   = {{(MASTERS-1){1'b0}}, 1'b1} << pick_idx;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = g_idx;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;

  // Counts on the master's raw STB so the forced-low STB cannot feed back
  assign to_fire = busy && g_stb && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || !busy || bus.ack_i || !g_stb || to_fire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign to_fire        = 1'b0;
`endif

  always_comb begin
    stb_int       = 1'b0;
    bus.cyc_o     = 1'b0;
    bus.stb_o     = 1'b0;
    bus.we_o      = 1'b0;
    bus.adr_o     = '0;
    bus.dat_o     = '0;
    bus.sel_o     = '0;
    bus.mst_ack_o = '0;
    bus.mst_err_o = '0;
    bus.mst_dat_o = '0;
    bus.gnt_o     = '0;
    if (busy) begin
      stb_int       = g_stb && !to_fire;
      bus.cyc_o     = 1'b1;
      bus.stb_o     = stb_int;
      bus.we_o      = g_we;
      bus.adr_o     = g_adr;
      bus.dat_o     = g_dat;
      bus.sel_o     = g_sel;
      // ACK without an active strobe is stray and never forwarded
      bus.mst_ack_o = gnt_q & {MASTERS{bus.ack_i && stb_int}};
      bus.mst_err_o = gnt_q & {MASTERS{to_fire}};
      bus.mst_dat_o = bus.dat_i;
      bus.gnt_o     = gnt_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_mst_arb.sv
// ============================================================================
// Module   : tb_wb_mst_arb
// Purpose  : Self-checking bench for wb_mst_arb with an ACK/data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_mst_arb;

  localparam int MASTERS = 4;
  localparam int AW      = 32;
  localparam int TIMEOUT = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  ack;
    logic [31:0] dat;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  wb_mst_arb_if #(.MASTERS(MASTERS), .AW(AW)) bus();

  wb_mst_arb #(.MASTERS(MASTERS), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: every forwarded ACK must match the oldest expected response
  always @(negedge clk_i) begin
    if (!rst_i && bus.mst_ack_o !== 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_ack: got ack=%b dat=%h, required no ack", bus.mst_ack_o, bus.mst_dat_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.mst_ack_o !== mon_e.ack || bus.mst_dat_o !== mon_e.dat) begin
          failures++;
          $display("FAIL sb_ack_data: got ack=%b dat=%h, required ack=%b dat=%h",
                   bus.mst_ack_o, bus.mst_dat_o, mon_e.ack, mon_e.dat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.mst_cyc_i = '0;
    bus.mst_stb_i = '0;
    bus.mst_we_i  = '0;
    bus.mst_adr_i = '0;
    bus.mst_dat_i = '0;
    bus.mst_sel_i = '0;
    bus.ack_i     = 1'b0;
    bus.dat_i     = '0;
  endtask

  task automatic set_master(input int m, input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.mst_cyc_i[m]          = cyc;
    bus.mst_stb_i[m]          = stb;
    bus.mst_we_i[m]           = we;
    bus.mst_adr_i[m*AW +: AW] = adr;
    bus.mst_dat_i[m*32 +: 32] = dat;
    bus.mst_sel_i[m*4 +: 4]   = sel;
  endtask

  task automatic drop_master(input int m);
    bus.mst_cyc_i[m] = 1'b0;
    bus.mst_stb_i[m] = 1'b0;
  endtask

  // One slave ACK in the current cycle; the response is queued for the scoreboard
  task automatic ack_once(input logic [3:0] mask, input logic [31:0] d);
    bus.ack_i = 1'b1;
    bus.dat_i = d;
    exp_q.push_back('{ack: mask, dat: d});
    tick();
    bus.ack_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i     = 1'b1;
    bus.ack_i = 1'b1;
    tick();
    tick();
    settle();
    checks++;
    if (bus.cyc_o !== 1'b0 || bus.stb_o !== 1'b0 || bus.gnt_o !== 4'b0000) begin
      failures++;
      $display("FAIL reset_bus: got cyc=%b stb=%b gnt=%b, required 0 0 0000", bus.cyc_o, bus.stb_o, bus.gnt_o);
    end
    checks++;
    if (bus.mst_ack_o !== 4'b0000 || bus.mst_err_o !== 4'b0000) begin
      failures++;
      $display("FAIL reset_resp: got ack=%b err=%b, required 0000 0000", bus.mst_ack_o, bus.mst_err_o);
    end
    bus.ack_i = 1'b0;
    rst_i     = 1'b0;
  endtask

  task automatic test_single();
    tick();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    settle();
    checks++;
    if (bus.stb_o !== 1'b0) begin
      failures++;
      $display("FAIL single_latency: got stb_o=%b in request cycle, required 0", bus.stb_o);
    end
    tick();
    settle();
    checks++;
    if (bus.stb_o !== 1'b1 || bus.adr_o !== 32'h0000_0100 || bus.gnt_o !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant: got stb=%b adr=%h gnt=%b, required 1 00000100 0001", bus.stb_o, bus.adr_o, bus.gnt_o);
    end
    tick();
    bus.ack_i = 1'b1;
    bus.dat_i = 32'h1111_2222;
    exp_q.push_back('{ack: 4'b0001, dat: 32'h1111_2222});
    settle();
    checks++;
    if (bus.mst_ack_o !== 4'b0001) begin
      failures++;
      $display("FAIL single_ack: got ack=%b, required 0001", bus.mst_ack_o);
    end
    tick();
    bus.ack_i = 1'b0;
    drop_master(0);
    settle();
    checks++;
    if (bus.mst_ack_o !== 4'b0000) begin
      failures++;
      $display("FAIL single_ack_len: got ack=%b after one cycle, required 0000", bus.mst_ack_o);
    end
    tick();
    settle();
    checks++;
    if (bus.cyc_o !== 1'b0 || bus.gnt_o !== 4'b0000) begin
      failures++;
      $display("FAIL single_release: got cyc=%b gnt=%b, required 0 0000", bus.cyc_o, bus.gnt_o);
    end
  endtask

  task automatic test_round_robin();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    set_master(3, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 4'b0110);
    tick();
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0010 || bus.adr_o !== 32'h0000_1000 || bus.we_o !== 1'b0) begin
      failures++;
      $display("FAIL rr_first: got gnt=%b adr=%h we=%b, required 0010 00001000 0", bus.gnt_o, bus.adr_o, bus.we_o);
    end
    ack_once(4'b0010, 32'h0101_0101);
    drop_master(1);
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0010) begin
      failures++;
      $display("FAIL rr_hold_drop: got gnt=%b in drop cycle, required 0010", bus.gnt_o);
    end
    tick();
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0000 || bus.cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL rr_dead_cycle: got gnt=%b cyc=%b, required 0000 0", bus.gnt_o, bus.cyc_o);
    end
    tick();
    settle();
    checks++;
    if (bus.gnt_o !== 4'b1000 || bus.adr_o !== 32'h0000_3000) begin
      failures++;
      $display("FAIL rr_second: got gnt=%b adr=%h, required 1000 00003000", bus.gnt_o, bus.adr_o);
    end
    checks++;
    if (bus.we_o !== 1'b1 || bus.dat_o !== 32'hDEAD_BEEF || bus.sel_o !== 4'b0110) begin
      failures++;
      $display("FAIL rr_write_mux: got we=%b dat=%h sel=%b, required 1 deadbeef 0110", bus.we_o, bus.dat_o, bus.sel_o);
    end
    ack_once(4'b1000, 32'h0303_0303);
    drop_master(3);
    tick();
    tick();
  endtask

  task automatic test_hold_burst();
    set_master(2, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
    tick();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0100) begin
      failures++;
      $display("FAIL hold_grant: got gnt=%b, required 0100", bus.gnt_o);
    end
    for (int i = 0; i < 3; i++) begin
      ack_once(4'b0100, 32'h0000_00A0 + i);
      settle();
      checks++;
      if (bus.gnt_o !== 4'b0100) begin
        failures++;
        $display("FAIL hold_during_burst: got gnt=%b after transfer %0d, required 0100", bus.gnt_o, i);
      end
    end
    drop_master(2);
    tick();
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0000) begin
      failures++;
      $display("FAIL hold_dead_cycle: got gnt=%b, required 0000", bus.gnt_o);
    end
    tick();
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0001) begin
      failures++;
      $display("FAIL hold_next: got gnt=%b, required 0001", bus.gnt_o);
    end
    ack_once(4'b0001, 32'h0000_00B0);
    drop_master(0);
    tick();
    tick();
  endtask

  task automatic test_read_route();
    set_master(1, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0, 4'hF);
    tick();
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0010 || bus.stb_o !== 1'b0) begin
      failures++;
      $display("FAIL read_grant: got gnt=%b stb=%b, required 0010 0", bus.gnt_o, bus.stb_o);
    end
    bus.ack_i = 1'b1;
    settle();
    checks++;
    if (bus.mst_ack_o !== 4'b0000) begin
      failures++;
      $display("FAIL stray_ack: got ack=%b with stb_o=0, required 0000", bus.mst_ack_o);
    end
    tick();
    bus.ack_i = 1'b0;
    bus.mst_stb_i[1] = 1'b1;
    bus.ack_i = 1'b1;
    bus.dat_i = 32'hCAFE_F00D;
    exp_q.push_back('{ack: 4'b0010, dat: 32'hCAFE_F00D});
    settle();
    checks++;
    if (bus.mst_ack_o !== 4'b0010 || bus.mst_dat_o !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL read_data: got ack=%b dat=%h, required 0010 cafef00d", bus.mst_ack_o, bus.mst_dat_o);
    end
    tick();
    bus.ack_i = 1'b0;
    drop_master(1);
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    set_master(2, 1'b1, 1'b1, 1'b0, 32'h0000_2200, 32'h0, 4'hF);
    tick();
    tick();
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0100 || bus.cyc_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre: got gnt=%b cyc=%b, required 0100 1", bus.gnt_o, bus.cyc_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    settle();
    checks++;
    if (bus.cyc_o !== 1'b0 || bus.gnt_o !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_clear: got cyc=%b gnt=%b, required 0 0000", bus.cyc_o, bus.gnt_o);
    end
    tick();
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_prio: got gnt=%b, required 0001", bus.gnt_o);
    end
    ack_once(4'b0001, 32'h0000_0C00);
    drop_master(0);
    tick();
    tick();
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0100) begin
      failures++;
      $display("FAIL rstmid_second: got gnt=%b, required 0100", bus.gnt_o);
    end
    ack_once(4'b0100, 32'h0000_0C02);
    drop_master(2);
    tick();
    tick();
  endtask

  task automatic test_timeout();
    logic [3:0] exp_err;
    logic       exp_stb;
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
    tick();
    for (int k = 0; k <= TIMEOUT; k++) begin
      settle();
      exp_err = (TO_EN && k == TIMEOUT - 1) ? 4'b0010 : 4'b0000;
      exp_stb = (TO_EN && k == TIMEOUT - 1) ? 1'b0 : 1'b1;
      checks++;
      if (bus.mst_err_o !== exp_err || bus.stb_o !== exp_stb) begin
        failures++;
        $display("FAIL timeout_k%0d: got err=%b stb=%b, required err=%b stb=%b",
                 k, bus.mst_err_o, bus.stb_o, exp_err, exp_stb);
      end
      tick();
    end
    drop_master(1);
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold_burst();
    test_read_route();
    test_reset_mid_burst();
    test_timeout();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d outstanding responses, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
